// File: rtl/reorg_copy_engine_if.sv
// Bus bundle for the reorg copy engine: upstream address pairs, the
// source-memory read port and the destination write port.
//
// Handshakes: an address pair moves on a cycle where addr_valid && addr_ready;
// a write moves on a cycle where wr_en && wr_ready, and while wr_en is high
// with wr_ready low the writer holds wr_en/wr_addr/wr_data unchanged. rd_en is
// a plain strobe with no back-pressure: rd_data answers exactly RD_LAT cycles
// later.
`timescale 1ns/1ps
interface reorg_copy_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] des_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    // Engine side.
    modport slave (
        input  addr_valid, src_addr, des_addr, rd_data, wr_ready,
        output addr_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    // Environment side: address generator, source memory, destination memory.
    modport master (
        output addr_valid, src_addr, des_addr, rd_data, wr_ready,
        input  addr_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/reorg_copy_engine.sv
// Layer copy engine: takes (src, des) address pairs, reads the source element,
// carries des alongside the read through a tag pipeline, buffers {des, data}
// in a small FIFO and writes it out in acceptance order. A credit check on
// outstanding elements keeps the FIFO from ever overflowing, so the push
// side needs no back-pressure.
`timescale 1ns/1ps
module reorg_copy_engine #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TOTAL      = 36864
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state,
    reorg_copy_engine_if.slave   bus
);
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, acc_cnt_inc;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, wr_cnt_inc;
    logic [CNT_W-1:0]  outstanding;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    // Stage 0 is the read-strobe cycle; stage RD_LAT lines up with rd_data.
    logic              pipe_v_q   [RD_LAT+1];
    logic              pipe_v_d   [RD_LAT+1];
    logic [ADDR_W-1:0] pipe_tag_q [RD_LAT+1];
    logic [ADDR_W-1:0] pipe_tag_d [RD_LAT+1];
    logic [ENT_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]  fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              addr_ready;
    logic              accept, push, pop, fifo_ne;
    logic [ENT_W-1:0]  head;

    // Handshake qualifiers, credit check and counter increments.
    always_comb begin
        fifo_ne     = (occ_q != '0);
        head        = fifo_mem_q[rd_ptr_q];
        pop         = fifo_ne && bus.wr_ready;
        push        = pipe_v_q[RD_LAT];
        wr_cnt_inc  = (pop && wr_cnt_q != TOTAL_C) ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
        // Counting this cycle's pop lets a full pipeline keep streaming one
        // pair per cycle; the entry being accepted can never land before it.
        outstanding = acc_cnt_q - wr_cnt_inc;
        addr_ready  = (state_q == S_RUN) && (acc_cnt_q != TOTAL_C)
                      && ({1'b0, outstanding} < DEPTH_C);
        accept      = bus.addr_valid && addr_ready;
        acc_cnt_inc = (accept && acc_cnt_q != TOTAL_C) ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;
    end

    // Layer FSM next state and counter updates.
    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_inc;
        wr_cnt_d  = wr_cnt_inc;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                end
            end
            S_RUN:   if (acc_cnt_inc == TOTAL_C) state_d = S_DRAIN;
            S_DRAIN: if (wr_cnt_inc == TOTAL_C)  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read strobe, read address and the des tag pipeline.
    always_comb begin
        rd_addr_d     = accept ? bus.src_addr : rd_addr_q;
        pipe_v_d[0]   = accept;
        pipe_tag_d[0] = accept ? bus.des_addr : '0;
        for (int i = 1; i <= RD_LAT; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
    end

    // Write-data FIFO: unconditional push from the tag pipeline, pop on write.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_d[i] = fifo_mem_q[i];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {pipe_tag_q[RD_LAT], bus.rd_data};
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    // Control state; everything here is cleared the moment reset_n drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            rd_addr_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_v_q[i]   <= 1'b0;
                pipe_tag_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            for (int i = 0; i <= RD_LAT; i++) begin
                pipe_v_q[i]   <= pipe_v_d[i];
                pipe_tag_q[i] <= pipe_tag_d[i];
            end
        end
    end

    // FIFO storage; stale contents are unreachable once occupancy is zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= fifo_mem_d[i];
    end

    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign dbg_state      = state_q;
    assign bus.addr_ready = addr_ready;
    assign bus.rd_en      = pipe_v_q[0];
    assign bus.rd_addr    = rd_addr_q;
    assign bus.wr_en      = fifo_ne;
    assign bus.wr_addr    = fifo_ne ? head[ENT_W-1:DATA_W] : '0;
    assign bus.wr_data    = fifo_ne ? head[DATA_W-1:0] : '0;
endmodule
